// File: rtl/idma_ch_event_bridge.sv
// -----------------------------------------------------------------------------
// idma_ch_event_bridge
//
// Turns the busy/start/done/error strobes of the iDMA transfer channels of a
// tile into single-cycle events for the tile event unit. Per channel it keeps
// an outstanding-transfer counter and coalesces done strobes into one done
// event per batch. The batch size is set by a threshold. A batch is also
// flushed early by a timeout, by the channel draining to zero outstanding
// transfers, or by an error strobe. Error strobes are forwarded one cycle
// later and are never coalesced. A single idle event is raised when every
// channel has gone quiet.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous soft clear; overrides every other input
//   ch_busy_i         per-channel busy level
//   ch_start_i        per-channel transfer-issued strobe
//   ch_done_i         per-channel transfer-retired strobe
//   ch_error_i        per-channel error strobe
//   cfg_thresh_i      per-channel done-coalescing threshold (0 acts as 1)
//   cfg_timeout_i     coalescing timeout in cycles (0 disables it)
//   evt_done_o        per-channel coalesced done pulse
//   evt_done_cnt_o    dones covered by the evt_done_o pulse (0 when no pulse)
//   evt_error_o       per-channel error pulse
//   evt_idle_o        all-channels-idle pulse
//   outstanding_o     registered outstanding-transfer count per channel
//   ovf_o, udf_o      sticky outstanding-counter overflow / underflow
//   stat_done_total_o per-channel 16-bit wrapping done total
//                     (present only with IDMA_EVT_STATS_EN defined)
//
// Optional feature macro: IDMA_EVT_STATS_EN
// -----------------------------------------------------------------------------
module idma_ch_event_bridge #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned TO_W   = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic [NUM_CH-1:0]       ch_busy_i,
   input  logic [NUM_CH-1:0]       ch_start_i,
   input  logic [NUM_CH-1:0]       ch_done_i,
   input  logic [NUM_CH-1:0]       ch_error_i,
   input  logic [NUM_CH*CNT_W-1:0] cfg_thresh_i,
   input  logic [TO_W-1:0]         cfg_timeout_i,
   output logic [NUM_CH-1:0]       evt_done_o,
   output logic [NUM_CH*CNT_W-1:0] evt_done_cnt_o,
   output logic [NUM_CH-1:0]       evt_error_o,
   output logic                    evt_idle_o,
   output logic [NUM_CH*CNT_W-1:0] outstanding_o,
   output logic [NUM_CH-1:0]       ovf_o,
`ifdef IDMA_EVT_STATS_EN
   output logic [NUM_CH-1:0]       udf_o,
   output logic [NUM_CH*16-1:0]    stat_done_total_o
`else
   output logic [NUM_CH-1:0]       udf_o
`endif
);

   localparam logic [CNT_W-1:0] CntZero  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
   localparam logic [TO_W-1:0]  TimerZero = {TO_W{1'b0}};
   localparam logic [TO_W-1:0]  TimerOne  = {{(TO_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0]  TimerMax  = {TO_W{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StFire
   } coal_state_e;

   // ---------------------------------------------------------------------------
   // Shared state: registered busy, error forwarding and idle detection
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] busy_q;
   logic [NUM_CH-1:0] err_q;
   logic [NUM_CH-1:0] out_zero;
   logic              prev_idle_q;
   logic              idle_evt_q;
   logic              all_idle;

   // Built only from registered values so the idle event never sees a
   // half-updated channel.
   assign all_idle = (busy_q == '0) && (&out_zero);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q      <= '0;
         err_q       <= '0;
         prev_idle_q <= 1'b1;
         idle_evt_q  <= 1'b0;
      end else if (clear_i) begin
         busy_q      <= '0;
         err_q       <= '0;
         prev_idle_q <= 1'b1;
         idle_evt_q  <= 1'b0;
      end else begin
         busy_q      <= ch_busy_i;
         err_q       <= ch_error_i;
         prev_idle_q <= all_idle;
         idle_evt_q  <= all_idle & ~prev_idle_q;
      end
   end

   assign evt_error_o = err_q;
   assign evt_idle_o  = idle_evt_q;

   // ---------------------------------------------------------------------------
   // Per-channel outstanding counter and done coalescing
   // ---------------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             start;
      logic             done;
      logic             err;
      logic [CNT_W-1:0] thresh_raw;
      logic [CNT_W-1:0] thresh_eff;
      logic             thresh_le1;

      assign start      = ch_start_i[c];
      assign done       = ch_done_i[c];
      assign err        = ch_error_i[c];
      assign thresh_raw = cfg_thresh_i[c*CNT_W +: CNT_W];
      assign thresh_eff = (thresh_raw == CntZero) ? CntOne : thresh_raw;
      assign thresh_le1 = (thresh_eff == CntOne);

      // Outstanding counter with sticky overflow/underflow flags
      logic [CNT_W-1:0] out_q, out_d;
      logic             ovf_q, ovf_d;
      logic             udf_q, udf_d;

      always_comb begin
         out_d = out_q;
         ovf_d = ovf_q;
         udf_d = udf_q;
         if (start && !done) begin
            if (out_q == CntMax) begin
               ovf_d = 1'b1;
            end else begin
               out_d = out_q + CntOne;
            end
         end else if (done && !start) begin
            if (out_q == CntZero) begin
               udf_d = 1'b1;
            end else begin
               out_d = out_q - CntOne;
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            out_q <= CntZero;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else if (clear_i) begin
            out_q <= CntZero;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
         end
      end

      assign outstanding_o[c*CNT_W +: CNT_W] = out_q;
      assign ovf_o[c]    = ovf_q;
      assign udf_o[c]    = udf_q;
      assign out_zero[c] = (out_q == CntZero);

      // Coalescing FSM
      coal_state_e      state_q;
      logic [CNT_W-1:0] pend_q;
      logic [TO_W-1:0]  timer_q;
      logic             evt_q;
      logic [CNT_W-1:0] evt_cnt_q;

      logic [CNT_W-1:0] pend_acc;
      logic [TO_W-1:0]  timer_inc;
      logic             timeout_hit;
      logic             fire_acc;

      // Pending count including a done seen this cycle, saturating
      assign pend_acc    = (done && (pend_q != CntMax)) ? (pend_q + CntOne) : pend_q;
      assign timer_inc   = (timer_q == TimerMax) ? timer_q : (timer_q + TimerOne);
      assign timeout_hit = (cfg_timeout_i != TimerZero) &&
                           (timer_q == (cfg_timeout_i - TimerOne));
      // Flush on threshold, timeout, channel drain or error
      assign fire_acc    = (pend_acc >= thresh_eff) || timeout_hit ||
                           (out_d == CntZero) || err;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q   <= StIdle;
            pend_q    <= CntZero;
            timer_q   <= TimerZero;
            evt_q     <= 1'b0;
            evt_cnt_q <= CntZero;
         end else if (clear_i) begin
            state_q   <= StIdle;
            pend_q    <= CntZero;
            timer_q   <= TimerZero;
            evt_q     <= 1'b0;
            evt_cnt_q <= CntZero;
         end else begin
            evt_q     <= 1'b0;
            evt_cnt_q <= CntZero;
            unique case (state_q)
               StIdle: begin
                  if (done) begin
                     pend_q  <= CntOne;
                     timer_q <= TimerZero;
                     state_q <= thresh_le1 ? StFire : StAccum;
                  end
               end
               StAccum: begin
                  pend_q  <= pend_acc;
                  timer_q <= timer_inc;
                  if (fire_acc) begin
                     state_q <= StFire;
                  end
               end
               StFire: begin
                  evt_q     <= 1'b1;
                  evt_cnt_q <= pend_q;
                  // A done landing in the fire cycle opens the next batch
                  if (done) begin
                     pend_q  <= CntOne;
                     timer_q <= TimerZero;
                     state_q <= thresh_le1 ? StFire : StAccum;
                  end else begin
                     pend_q  <= CntZero;
                     state_q <= StIdle;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  pend_q  <= CntZero;
               end
            endcase
         end
      end

      assign evt_done_o[c]                    = evt_q;
      assign evt_done_cnt_o[c*CNT_W +: CNT_W] = evt_cnt_q;

`ifdef IDMA_EVT_STATS_EN
      // Free-running done total, wraps at 16 bits
      logic [15:0] stat_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            stat_q <= 16'd0;
         end else if (clear_i) begin
            stat_q <= 16'd0;
         end else if (done) begin
            stat_q <= stat_q + 16'd1;
         end
      end

      assign stat_done_total_o[c*16 +: 16] = stat_q;
`endif
   end

endmodule

// File: tb/tb_idma_ch_event_bridge.sv
// -----------------------------------------------------------------------------
// Bench for idma_ch_event_bridge. A transaction-level reference model runs
// alongside the stimulus and queues the events (done, error, idle) and the
// per-edge counter state the DUT must show; a monitor on the falling edge
// compares whatever the DUT presents against those queues.
// -----------------------------------------------------------------------------
module tb_idma_ch_event_bridge;

   localparam int NCH = 2;
   localparam int CW  = 4;
   localparam int TW  = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear = 1'b0;
   logic [NCH-1:0]   ch_busy = '0;
   logic [NCH-1:0]   ch_start = '0;
   logic [NCH-1:0]   ch_done = '0;
   logic [NCH-1:0]   ch_error = '0;
   logic [NCH*CW-1:0] cfg_thresh = '0;
   logic [TW-1:0]    cfg_timeout = '0;

   logic [NCH-1:0]    evt_done;
   logic [NCH*CW-1:0] evt_done_cnt;
   logic [NCH-1:0]    evt_error;
   logic              evt_idle;
   logic [NCH*CW-1:0] outstanding;
   logic [NCH-1:0]    ovf;
   logic [NCH-1:0]    udf;
`ifdef IDMA_EVT_STATS_EN
   logic [NCH*16-1:0] stat_total;
`endif

   idma_ch_event_bridge #(
      .NUM_CH (NCH),
      .CNT_W  (CW),
      .TO_W   (TW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear),
      .ch_busy_i      (ch_busy),
      .ch_start_i     (ch_start),
      .ch_done_i      (ch_done),
      .ch_error_i     (ch_error),
      .cfg_thresh_i   (cfg_thresh),
      .cfg_timeout_i  (cfg_timeout),
      .evt_done_o     (evt_done),
      .evt_done_cnt_o (evt_done_cnt),
      .evt_error_o    (evt_error),
      .evt_idle_o     (evt_idle),
      .outstanding_o  (outstanding),
      .ovf_o          (ovf),
`ifdef IDMA_EVT_STATS_EN
      .udf_o          (udf),
      .stat_done_total_o (stat_total)
`else
      .udf_o          (udf)
`endif
   );

   always #5 clk = ~clk;

   // Number of rising edges so far
   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard queues (e = edge after which the value must be visible)
   // ---------------------------------------------------------------------------
   typedef struct packed {
      int e;
      int ch;
      int cnt;
   } evt_t;

   typedef struct packed {
      int          e;
      logic [7:0]  out;
      logic [1:0]  ovf;
      logic [1:0]  udf;
      logic [31:0] stat;
   } rec_t;

   evt_t dq[$];
   evt_t eq[$];
   evt_t iq[$];
   rec_t rq[$];

   // ---------------------------------------------------------------------------
   // Reference model: batches of dones per channel
   // ---------------------------------------------------------------------------
   int m_out [NCH];
   bit m_ovf [NCH];
   bit m_udf [NCH];
   bit m_open [NCH];
   int m_pend [NCH];
   int m_open_e [NCH];
   int m_stat [NCH];
   bit m_last_ai = 1'b1;

   task automatic model(input int E, input logic [NCH-1:0] s, input logic [NCH-1:0] d,
                        input logic [NCH-1:0] er, input logic [NCH-1:0] b, input bit clr);
      int th;
      bit fire;
      bit ai;
      rec_t r;
      if (clr) begin
         for (int c = 0; c < NCH; c++) begin
            m_out[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
            m_open[c] = 0; m_pend[c] = 0; m_stat[c] = 0;
         end
         m_last_ai = 1'b1;
         // Events due at or after the clearing edge never appear
         while (dq.size() > 0 && dq[dq.size()-1].e >= E) dq.delete(dq.size()-1);
         while (eq.size() > 0 && eq[eq.size()-1].e >= E) eq.delete(eq.size()-1);
         while (iq.size() > 0 && iq[iq.size()-1].e >= E) iq.delete(iq.size()-1);
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (s[c] && !d[c]) begin
               if (m_out[c] == 15) m_ovf[c] = 1; else m_out[c]++;
            end else if (d[c] && !s[c]) begin
               if (m_out[c] == 0) m_udf[c] = 1; else m_out[c]--;
            end
            th = int'(cfg_thresh[c*CW +: CW]);
            if (th == 0) th = 1;
            fire = 0;
            if (m_open[c]) begin
               if (d[c] && m_pend[c] < 15) m_pend[c]++;
               if (m_pend[c] >= th) fire = 1;
               if (cfg_timeout != 0 && (E - m_open_e[c]) == int'(cfg_timeout)) fire = 1;
               if (m_out[c] == 0) fire = 1;
               if (er[c]) fire = 1;
            end else if (d[c]) begin
               m_open[c] = 1; m_pend[c] = 1; m_open_e[c] = E;
               if (th == 1) fire = 1;
            end
            if (fire) begin
               dq.push_back('{e: E + 1, ch: c, cnt: m_pend[c]});
               m_open[c] = 0;
            end
            if (er[c]) eq.push_back('{e: E, ch: c, cnt: 0});
            if (d[c]) m_stat[c] = (m_stat[c] + 1) % 65536;
         end
         ai = (b == '0);
         for (int c = 0; c < NCH; c++) if (m_out[c] != 0) ai = 0;
         if (ai && !m_last_ai) iq.push_back('{e: E + 1, ch: 0, cnt: 0});
         m_last_ai = ai;
      end
      r.e = E;
      r.out = {m_out[1][3:0], m_out[0][3:0]};
      r.ovf = {m_ovf[1], m_ovf[0]};
      r.udf = {m_udf[1], m_udf[0]};
      r.stat = {m_stat[1][15:0], m_stat[0][15:0]};
      rq.push_back(r);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   bit mon_en = 1'b0;
   int seen_done [NCH];
   int seen_sum [NCH];
   int seen_err [NCH];
   int seen_idle = 0;
   bit m_hit;
   int m_cnt;

   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < NCH; c++) begin
            m_hit = 1'b0; m_cnt = 0;
            foreach (dq[i]) if (dq[i].e == ecnt && dq[i].ch == c) begin
               m_hit = 1'b1; m_cnt = dq[i].cnt;
            end
            chk($sformatf("evt_done_o[%0d] edge %0d", c, ecnt), int'(evt_done[c]), int'(m_hit));
            if (m_hit && evt_done[c])
               chk($sformatf("evt_done_cnt_o[%0d] edge %0d", c, ecnt),
                   int'(evt_done_cnt[c*CW +: CW]), m_cnt);
            if (evt_done[c]) begin
               seen_done[c]++;
               seen_sum[c] += int'(evt_done_cnt[c*CW +: CW]);
            end
            m_hit = 1'b0;
            foreach (eq[i]) if (eq[i].e == ecnt && eq[i].ch == c) m_hit = 1'b1;
            chk($sformatf("evt_error_o[%0d] edge %0d", c, ecnt), int'(evt_error[c]), int'(m_hit));
            if (evt_error[c]) seen_err[c]++;
         end
         m_hit = 1'b0;
         foreach (iq[i]) if (iq[i].e == ecnt) m_hit = 1'b1;
         chk($sformatf("evt_idle_o edge %0d", ecnt), int'(evt_idle), int'(m_hit));
         if (evt_idle) seen_idle++;
         while (dq.size() > 0 && dq[0].e <= ecnt) dq.delete(0);
         while (eq.size() > 0 && eq[0].e <= ecnt) eq.delete(0);
         while (iq.size() > 0 && iq[0].e <= ecnt) iq.delete(0);
         while (rq.size() > 0 && rq[0].e < ecnt) rq.delete(0);
         if (rq.size() > 0 && rq[0].e == ecnt) begin
            chk($sformatf("outstanding_o edge %0d", ecnt), int'(outstanding), int'(rq[0].out));
            chk($sformatf("ovf_o edge %0d", ecnt), int'(ovf), int'(rq[0].ovf));
            chk($sformatf("udf_o edge %0d", ecnt), int'(udf), int'(rq[0].udf));
`ifdef IDMA_EVT_STATS_EN
            chk($sformatf("stat_done_total_o edge %0d", ecnt), int'(stat_total), int'(rq[0].stat));
`endif
            rq.delete(0);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus (called at rising edge + 1)
   // ---------------------------------------------------------------------------
   task automatic step(input logic [NCH-1:0] s, input logic [NCH-1:0] d,
                       input logic [NCH-1:0] er, input logic [NCH-1:0] b, input bit clr);
      ch_start = s; ch_done = d; ch_error = er; ch_busy = b; clear = clr;
      model(ecnt + 1, s, d, er, b, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic rep(input int n, input logic [NCH-1:0] s, input logic [NCH-1:0] d);
      for (int i = 0; i < n; i++) step(s, d, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic quiet(input int n);
      rep(n, 2'b00, 2'b00);
   endtask

   int b_done0, b_sum0, b_done1, b_sum1, b_idle, b_err1;

   task automatic mark();
      b_done0 = seen_done[0]; b_sum0 = seen_sum[0];
      b_done1 = seen_done[1]; b_sum1 = seen_sum[1];
      b_idle = seen_idle; b_err1 = seen_err[1];
   endtask

   logic [NCH-1:0] rs, rd, re, rb;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_out[c] = 0; m_ovf[c] = 0; m_udf[c] = 0; m_open[c] = 0;
         m_pend[c] = 0; m_open_e[c] = 0; m_stat[c] = 0;
         seen_done[c] = 0; seen_sum[c] = 0; seen_err[c] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Reset state
      chk("reset evt_done_o", int'(evt_done), 0);
      chk("reset evt_done_cnt_o", int'(evt_done_cnt), 0);
      chk("reset evt_error_o", int'(evt_error), 0);
      chk("reset evt_idle_o", int'(evt_idle), 0);
      chk("reset outstanding_o", int'(outstanding), 0);
      chk("reset ovf_o", int'(ovf), 0);
      chk("reset udf_o", int'(udf), 0);
      mon_en = 1'b1;

      // Single transfer, threshold 1
      cfg_thresh = {4'd1, 4'd1}; cfg_timeout = 8'd0;
      mark();
      step(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      chk("t1 outstanding after start", int'(outstanding[3:0]), 1);
      step(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      chk("t1 outstanding after done", int'(outstanding[3:0]), 0);
      quiet(4);
      chk("t1 done pulses", seen_done[0] - b_done0, 1);
      chk("t1 done count sum", seen_sum[0] - b_sum0, 1);
      chk("t1 idle pulses", seen_idle - b_idle, 1);

      // Threshold 4 on ch1
      cfg_thresh = {4'd4, 4'd1};
      mark();
      rep(6, 2'b10, 2'b00);
      rep(4, 2'b00, 2'b10);
      quiet(4);
      chk("t2 done pulses", seen_done[1] - b_done1, 1);
      chk("t2 done count sum", seen_sum[1] - b_sum1, 4);
      chk("t2 outstanding", int'(outstanding[7:4]), 2);
      chk("t2 idle pulses", seen_idle - b_idle, 0);
      rep(2, 2'b00, 2'b10);
      quiet(4);

      // Timeout flush then drain flush on ch0
      cfg_thresh = {4'd4, 4'd8}; cfg_timeout = 8'd10;
      rep(3, 2'b01, 2'b00);
      mark();
      rep(2, 2'b00, 2'b01);
      quiet(14);
      chk("t3 timeout pulses", seen_done[0] - b_done0, 1);
      chk("t3 timeout count", seen_sum[0] - b_sum0, 2);
      mark();
      step(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      quiet(5);
      chk("t3 drain pulses", seen_done[0] - b_done0, 1);
      chk("t3 drain count", seen_sum[0] - b_sum0, 1);

      // Dones landing in the fire cycle, threshold 2 on ch1
      cfg_thresh = {4'd2, 4'd8}; cfg_timeout = 8'd0;
      rep(10, 2'b10, 2'b00);
      mark();
      rep(8, 2'b00, 2'b10);
      quiet(4);
      chk("t4 done pulses", seen_done[1] - b_done1, 4);
      chk("t4 done count sum", seen_sum[1] - b_sum1, 8);
      rep(2, 2'b00, 2'b10);
      quiet(4);

      // Overflow, underflow, clear
      rep(16, 2'b01, 2'b00);
      chk("t5 outstanding saturates", int'(outstanding[3:0]), 15);
      chk("t5 ovf set", int'(ovf[0]), 1);
      step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      step(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      chk("t5 udf set", int'(udf[0]), 1);
      quiet(4);
      step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      chk("t5 clear ovf", int'(ovf), 0);
      chk("t5 clear udf", int'(udf), 0);
      chk("t5 clear outstanding", int'(outstanding), 0);
      quiet(2);

      // Error flush on ch1 with one done pending
      cfg_thresh = {4'd4, 4'd8};
      rep(2, 2'b10, 2'b00);
      mark();
      step(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
      step(2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
      quiet(4);
      chk("t6 error pulses", seen_err[1] - b_err1, 1);
      chk("t6 done pulses", seen_done[1] - b_done1, 1);
      chk("t6 done count", seen_sum[1] - b_sum1, 1);
      step(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
      quiet(4);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) cfg_thresh = 8'($urandom);
         if (i % 150 == 0) cfg_timeout = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(20, 1));
         for (int c = 0; c < NCH; c++) begin
            rs[c] = ($urandom_range(2, 0) == 0);
            rd[c] = ($urandom_range(2, 0) == 0);
            re[c] = ($urandom_range(15, 0) == 0);
            rb[c] = ($urandom_range(3, 0) == 0);
         end
         step(rs, rd, re, rb, ($urandom_range(299, 0) == 0));
      end
      quiet(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
